// File: rtl/dmem_responder.sv
// Wait-stated data memory slave with RISC-V B/H/W access sizing; response WAIT_CYCLES+1 cycles after accept.
// One request in flight: req_ready drops on accept and returns only after the response handshake.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [31:0]   w_load;
  logic [31:0]   w_wrep;
  logic [31:0]   w_store_word;
  logic [3:0]    w_be;
  logic          w_illegal;
  logic          w_misalign;
  logic          w_oor;
  logic          w_err;
  logic          w_mem_we;

  assign w_idx  = r_addr[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_oor  = |r_addr[31:AW+2];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = r_addr[0] ? w_half[15:8] : w_half[7:0];

  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_load     = 32'h0;
    w_wrep     = r_wdata;
    case (r_funct3)
      3'b000: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_load = {{24{w_byte[7]}}, w_byte};
        w_wrep = {4{r_wdata[7:0]}};
      end
      3'b001: begin
        w_misalign = r_addr[0];
        w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
        w_load     = {{16{w_half[15]}}, w_half};
        w_wrep     = {2{r_wdata[15:0]}};
      end
      3'b010: begin
        w_misalign = |r_addr[1:0];
        w_be       = 4'b1111;
        w_load     = w_word;
      end
      3'b100: begin
        w_illegal = r_we;
        w_load    = {24'h0, w_byte};
      end
      3'b101: begin
        w_illegal  = r_we;
        w_misalign = r_addr[0];
        w_load     = {16'h0, w_half};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Lane merge: replicated store data lands only on enabled bytes, the rest keep the old word.
  always_comb begin
    w_store_word = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_store_word[8*i +: 8] = w_wrep[8*i +: 8];
    end
  end

  assign w_err    = w_illegal | w_misalign | w_oor;
  assign w_mem_we = (r_state == WAIT) && (r_cnt == 4'd0) && r_we && !w_err && !rst;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_store_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 4'(WAIT_CYCLES);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: byte-addressed memory model plus per-cycle response compare.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [DEPTH];
  int          nvec = 0;
  int          nmis = 0;
  int          cyc = 0;
  bit          first_seen = 1'b0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nmis++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference memory: byte lanes by address arithmetic, size from funct3, errors from the access rules.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int unsigned idx;
    int          off;
    int          size;
    logic [31:0] w;
    logic [31:0] v;
    idx  = (a / 4) % DEPTH;
    off  = int'(a % 4);
    w    = mem_m[idx];
    rd   = 32'h0;
    er   = 1'b0;
    size = 0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    er = 1'b1;
    endcase
    if (we && f3 >= 3'd4) er = 1'b1;
    if (a >= 32'(DEPTH * 4)) er = 1'b1;
    if (size > 0) begin
      if ((off % size) != 0) er = 1'b1;
    end
    if (!er) begin
      if (we) begin
        for (int b = 0; b < size; b++) w[(off + b) * 8 +: 8] = wd[b * 8 +: 8];
        mem_m[idx] = w;
      end else begin
        v = w >> (off * 8);
        if (size == 1)      rd = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (size == 2) rd = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else                rd = v;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst && rsp_valid && rsp_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      first_seen = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
      end else begin
        check("rsp_rdata", rsp_rdata, exp_q[0].rd);
        check("rsp_err", 32'(rsp_err), 32'(exp_q[0].err));
        check("req_ready_in_resp", 32'(req_ready), 32'h0);
        if (!first_seen) begin
          check("rsp_latency", 32'(cyc - exp_q[0].acc), 32'(WAITC + 1));
          first_seen = 1'b1;
        end
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
      end
    end
  end

  task automatic txn(input string name, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] lit_rd, input logic lit_err, input bit hold);
    logic [31:0] er_d;
    logic        er_e;
    logic [31:0] held;
    exp_t        e;
    int          n;
    model(we, f3, a, wd, er_d, er_e);
    @(negedge clk);
    rsp_ready  = !hold;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) timeout({name, "_accept"});
    e.rd = er_d; e.err = er_e; e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    if (hold) begin
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) timeout({name, "_rsp"});
      held = rsp_rdata;
      for (int k = 0; k < 5; k++) begin
        check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
        check("stall_rsp_rdata", rsp_rdata, held);
        check("stall_req_ready", 32'(req_ready), 32'h0);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'h1111_1111;
        @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      timeout({name, "_done"});
      exp_q.delete();
    end
    check({name, "_rdata"}, last_rdata, lit_rd);
    check({name, "_err"}, 32'(last_err), 32'(lit_err));
  endtask

  task automatic abort_store(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    check("abort_pre_req_ready", 32'(req_ready), 32'h1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
    check("abort_req_ready", 32'(req_ready), 32'h1);
    check("abort_rsp_err", 32'(rsp_err), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);

    txn("sw_10",    1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0);
    txn("lw_10",    1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    txn("sb_11",    1'b1, 3'b000, 32'h11, 32'h0000_0080, 32'h0,         1'b0, 1'b0);
    txn("lb_11",    1'b0, 3'b000, 32'h11, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0);
    txn("lbu_11",   1'b0, 3'b100, 32'h11, 32'h0,         32'h0000_0080, 1'b0, 1'b0);
    txn("lw_10b",   1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0, 1'b0);
    txn("lw_12",    1'b0, 3'b010, 32'h12, 32'h0,         32'h0,         1'b1, 1'b0);
    txn("sh_13",    1'b1, 3'b001, 32'h13, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
    txn("lw_10c",   1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0, 1'b0);
    txn("lw_400",   1'b0, 3'b010, 32'h400, 32'h0,        32'h0,         1'b1, 1'b0);
    txn("f3_011",   1'b0, 3'b011, 32'h10, 32'h0,         32'h0,         1'b1, 1'b0);
    txn("sbu_10",   1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
    txn("sw_f3_111",1'b1, 3'b111, 32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0);
    txn("lw_10d",   1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0, 1'b0);

    txn("sw_14",    1'b1, 3'b010, 32'h14, 32'h0,         32'h0,         1'b0, 1'b0);
    txn("sh_16",    1'b1, 3'b001, 32'h16, 32'hABCD_F00D, 32'h0,         1'b0, 1'b0);
    txn("lh_16",    1'b0, 3'b001, 32'h16, 32'h0,         32'hFFFF_F00D, 1'b0, 1'b0);
    txn("lhu_16",   1'b0, 3'b101, 32'h16, 32'h0,         32'h0000_F00D, 1'b0, 1'b0);
    txn("lb_17",    1'b0, 3'b000, 32'h17, 32'h0,         32'hFFFF_FFF0, 1'b0, 1'b0);
    txn("lw_14",    1'b0, 3'b010, 32'h14, 32'h0,         32'hF00D_0000, 1'b0, 1'b0);
    txn("lh_15",    1'b0, 3'b001, 32'h15, 32'h0,         32'h0,         1'b1, 1'b0);

    txn("lw_stall", 1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0, 1'b1);
    txn("lw_10e",   1'b0, 3'b010, 32'h10, 32'h0,         32'hDEAD_80EF, 1'b0, 1'b0);

    txn("sw_20",    1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0);
    abort_store(32'h20, 32'h1234_5678);
    txn("lw_20",    1'b0, 3'b010, 32'h20, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
